// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter in front of a single-port data memory
// Each transaction is latched in IDLE, driven to memory in ACCESS, and loads report in RESP.
module mem_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  state_t            next_state;
  logic              win;
  logic              win_q;
  logic              write_q;
  logic              last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  // Tie-break: round-robin favours the port that did not win last time.
  always_comb begin
    win = 1'b0;
    if (req0_valid && req1_valid)
      win = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    else if (req1_valid)
      win = 1'b1;
  end

  always_comb begin
    next_state  = state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    req0_rvalid = 1'b0;
    req1_rvalid = 1'b0;
    mem_write   = 1'b0;
    grant       = 2'b00;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid)
          next_state = ACCESS;
      end
      ACCESS: begin
        mem_write  = write_q;
        req0_ready = ~win_q;
        req1_ready = win_q;
        grant      = win_q ? 2'b10 : 2'b01;
        next_state = write_q ? IDLE : RESP;
      end
      RESP: begin
        req0_rvalid = ~win_q;
        req1_rvalid = win_q;
        grant       = win_q ? 2'b10 : 2'b01;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      win_q      <= 1'b0;
      write_q    <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && (req0_valid || req1_valid)) begin
        win_q      <= win;
        last_grant <= win;
        write_q    <= win ? req1_write : req0_write;
        addr_q     <= win ? req1_addr  : req0_addr;
        wdata_q    <= win ? req1_wdata : req0_wdata;
      end
      if (state == ACCESS && !write_q) begin
        if (win_q)
          rdata1_q <= mem_read_data;
        else
          rdata0_q <= mem_read_data;
      end
    end
  end

  // The latch registers only change on acceptance, so memory-side buses hold between accesses.
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign req0_rdata     = rdata0_q;
  assign req1_rdata     = rdata1_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
// dut_rr uses round-robin, dut_fp fixed priority; both see identical requests.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req0_write = 1'b0;
  logic [15:0] req0_addr = '0, req0_wdata = '0;
  logic        req1_valid = 1'b0, req1_write = 1'b0;
  logic [15:0] req1_addr = '0, req1_wdata = '0;

  logic        r_ready0, r_ready1, r_rvalid0, r_rvalid1, r_mwr, r_busy;
  logic [15:0] r_rdata0, r_rdata1, r_maddr, r_mwdata, r_mrdata;
  logic [1:0]  r_grant;
  logic        f_ready0, f_ready1, f_rvalid0, f_rvalid1, f_mwr, f_busy;
  logic [15:0] f_rdata0, f_rdata1, f_maddr, f_mwdata, f_mrdata;
  logic [1:0]  f_grant;

  int errors = 0;
  int checks = 0;
  int rv0, rv1, frv1;
  logic [1:0] exp_r [6] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
  logic [1:0] exp_f [3] = '{2'b01, 2'b01, 2'b00};

  // Unwritten words read back as A5 followed by the low address byte.
  logic [15:0]  mem_r [256];
  logic [255:0] vld_r = '0;
  logic [15:0]  mem_f [256];
  logic [255:0] vld_f = '0;

  assign r_mrdata = vld_r[r_maddr[7:0]] ? mem_r[r_maddr[7:0]] : {8'hA5, r_maddr[7:0]};
  assign f_mrdata = vld_f[f_maddr[7:0]] ? mem_f[f_maddr[7:0]] : {8'hA5, f_maddr[7:0]};

  always @(posedge clk) begin
    if (r_mwr) begin
      mem_r[r_maddr[7:0]] <= r_mwdata;
      vld_r[r_maddr[7:0]] <= 1'b1;
    end
    if (f_mwr) begin
      mem_f[f_maddr[7:0]] <= f_mwdata;
      vld_f[f_maddr[7:0]] <= 1'b1;
    end
  end

  always #5 clk = ~clk;

  mem_arbiter #(.FIXED_PRIO(0), .ADDR_W(16), .DATA_W(16)) dut_rr (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(r_ready0), .req0_rvalid(r_rvalid0), .req0_rdata(r_rdata0),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(r_ready1), .req1_rvalid(r_rvalid1), .req1_rdata(r_rdata1),
    .mem_address(r_maddr), .mem_write_data(r_mwdata), .mem_write(r_mwr),
    .mem_read_data(r_mrdata), .grant(r_grant), .busy(r_busy)
  );

  mem_arbiter #(.FIXED_PRIO(1), .ADDR_W(16), .DATA_W(16)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(f_ready0), .req0_rvalid(f_rvalid0), .req0_rdata(f_rdata0),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(f_ready1), .req1_rvalid(f_rvalid1), .req1_rdata(f_rdata1),
    .mem_address(f_maddr), .mem_write_data(f_mwdata), .mem_write(f_mwr),
    .mem_read_data(f_mrdata), .grant(f_grant), .busy(f_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_grant", r_grant, 2'b00);
    chk("rst_busy", r_busy, 1'b0);
    chk("rst_mwr", r_mwr, 1'b0);
    chk("rst_maddr", r_maddr, 16'h0);
    chk("rst_mwdata", r_mwdata, 16'h0);
    chk("rst_rdy_rv", {r_ready0, r_ready1, r_rvalid0, r_rvalid1}, 4'b0);
    chk("rst_rdata", {r_rdata0, r_rdata1}, 32'h0);
    step();
    reset = 1'b1;

    // Port 0 store 0x0010 <- 0xBEEF
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 16'h0010; req0_wdata = 16'hBEEF;
    step();
    chk("st_mwr", r_mwr, 1'b1);
    chk("st_maddr", r_maddr, 16'h0010);
    chk("st_mwdata", r_mwdata, 16'hBEEF);
    chk("st_ready0", r_ready0, 1'b1);
    chk("st_grant", r_grant, 2'b01);
    chk("st_busy", r_busy, 1'b1);
    req0_valid = 1'b0;
    step();
    chk("st_idle_busy", r_busy, 1'b0);
    chk("st_idle_mwr", r_mwr, 1'b0);
    chk("st_hold_maddr", r_maddr, 16'h0010);
    chk("st_mem", mem_r[8'h10], 16'hBEEF);

    // Port 1 load of the same word
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 16'h0010;
    step();
    chk("ld1_ready", r_ready1, 1'b1);
    chk("ld1_ready0", r_ready0, 1'b0);
    chk("ld1_grant", r_grant, 2'b10);
    chk("ld1_mwr", r_mwr, 1'b0);
    req1_valid = 1'b0;
    step();
    chk("ld1_rvalid", r_rvalid1, 1'b1);
    chk("ld1_rdata", r_rdata1, 16'hBEEF);
    chk("ld1_rdata0", r_rdata0, 16'h0);
    chk("ld1_rvalid0", r_rvalid0, 1'b0);
    chk("ld1_resp_grant", r_grant, 2'b10);
    step();
    chk("ld1_idle", r_busy, 1'b0);

    // Port 0 load; port 1 raises valid in RESP and must wait for IDLE
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 16'h0010;
    step();
    chk("ld0_ready", r_ready0, 1'b1);
    req0_valid = 1'b0;
    step();
    chk("ld0_rvalid", r_rvalid0, 1'b1);
    chk("ld0_rdata", r_rdata0, 16'hBEEF);
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 16'h0020;
    step();
    chk("late_idle_busy", r_busy, 1'b0);
    chk("late_no_ready", r_ready1, 1'b0);
    step();
    chk("late_ready", r_ready1, 1'b1);
    chk("late_grant", r_grant, 2'b10);
    req1_valid = 1'b0;
    step();
    chk("late_rdata", r_rdata1, 16'hA520);
    chk("late_rdata0_keep", r_rdata0, 16'hBEEF);
    step();

    // Both ports hold loads continuously
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 16'h0010;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 16'h0020;
    rv0 = 0; rv1 = 0; frv1 = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("rr_grant%0d", i), r_grant, exp_r[i % 6]);
      chk($sformatf("fp_grant%0d", i), f_grant, exp_f[i % 3]);
      rv0 += int'(r_rvalid0);
      rv1 += int'(r_rvalid1);
      frv1 += int'(f_rvalid1);
    end
    chk("rr_rv0_count", rv0, 2);
    chk("rr_rv1_count", rv1, 2);
    chk("fp_rv1_count", frv1, 0);
    req0_valid = 1'b0;
    step();
    chk("fp_p1_after_drop", f_grant, 2'b10);
    chk("rr_p1_after_drop", r_grant, 2'b10);
    req1_valid = 1'b0;
    step();
    step();
    chk("drain_idle", r_busy, 1'b0);

    // Reset pulsed during the ACCESS of a store
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 16'h0030; req0_wdata = 16'hAAAA;
    step();
    chk("rst_acc_mwr", r_mwr, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_acc_mwr_drop", r_mwr, 1'b0);
    chk("rst_acc_ready", r_ready0, 1'b0);
    chk("rst_acc_busy", r_busy, 1'b0);
    chk("rst_acc_grant", r_grant, 2'b00);
    chk("rst_acc_rdata", r_rdata0, 16'h0);
    req0_valid = 1'b0;
    step();
    reset = 1'b1;
    chk("rst_acc_mem", vld_r[8'h30], 1'b0);

    // First tie after reset goes to port 0
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 16'h0030;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 16'h0020;
    step();
    chk("post_rst_tie", r_grant, 2'b01);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("post_rst_rdata", r_rdata0, 16'hA530);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0, 0 = round-robin arbitration, 1 = port 0 always wins ties.
REQ-002 Parameter ADDR_W, default 16, width of address buses.
REQ-003 Parameter DATA_W, default 16, width of data buses.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately, regardless of clk.
REQ-006 reqN_valid  input  1  port N (N=0,1) access request, held until reqN_ready.
REQ-007 reqN_write  input  1  port N: 1 = store, 0 = load.
REQ-008 reqN_addr  input  ADDR_W  port N word address.
REQ-009 reqN_wdata  input  DATA_W  port N store data.
REQ-010 reqN_ready  output  1  port N request accepted, one-cycle pulse.
REQ-011 reqN_rvalid  output  1  port N load data valid, one-cycle pulse.
REQ-012 reqN_rdata  output  DATA_W  port N load data, held until the next port N load completes.
REQ-013 mem_address  output  ADDR_W  address to single-port data memory.
REQ-014 mem_write_data  output  DATA_W  store data to data memory.
REQ-015 mem_write  output  1  data memory write enable, sampled by memory on rising clk.
REQ-016 mem_read_data  input  DATA_W  data memory combinational read data for current mem_address.
REQ-017 grant  output  2  one-hot owner of the memory, 00 when idle.
REQ-018 busy  output  1  1 whenever state is not IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-020 IDLE: if any reqN_valid=1, arbiter SHALL latch winner index, write, addr, wdata and move to ACCESS next cycle; else stay IDLE.
REQ-021 Arbitration, FIXED_PRIO=0: single requester wins; both valid -> port not equal to last_grant wins; last_grant updates on each latch.
REQ-022 Arbitration, FIXED_PRIO=1: port 0 wins whenever req0_valid=1.
REQ-023 ACCESS: mem_address = latched addr, mem_write_data = latched wdata, mem_write = latched write, winner reqN_ready=1, grant = winner one-hot, all for exactly one cycle.
REQ-024 ACCESS, store: next state IDLE; store latency valid->ready = 2 cycles, occupancy 2 cycles.
REQ-025 ACCESS, load: mem_read_data SHALL be captured into winner reqN_rdata at the end of the ACCESS cycle; next state RESP.
REQ-026 RESP: winner reqN_rvalid=1 for one cycle, grant held, mem_write=0; next state IDLE; load latency valid->rvalid = 3 cycles.
REQ-027 Outside ACCESS, mem_write SHALL be 0 and mem_address/mem_write_data SHALL hold their last driven values.
REQ-028 Requests SHALL never be accepted outside IDLE; a valid raised during ACCESS/RESP waits and is arbitrated in the next IDLE.
REQ-029 Non-winning port's ready/rvalid SHALL stay 0 and its rdata unchanged.
REQ-030 Requester dropping valid after latching SHALL NOT abort the transaction; it completes as latched.
REQ-031 Address and data SHALL pass unmodified; no wrap or arithmetic on addr.

Reset
REQ-032 reset=0 SHALL force state IDLE, last_grant=1, grant=00, busy=0, mem_write=0, mem_address=0, mem_write_data=0, all ready/rvalid=0, both rdata=0.
REQ-033 reset asserted during ACCESS SHALL drop mem_write to 0 immediately; the in-flight transaction is discarded, no ready/rvalid issued.
REQ-034 After reset deasserts, first tie SHALL be granted to port 0.

Verification
REQ-035 Port 0 store addr=0x0010 data=0xBEEF alone -> cycle+1 ACCESS: mem_write=1, mem_address=0x0010, req0_ready=1; cycle+2 IDLE, busy=0.
REQ-036 Port 1 load addr=0x0010 after REQ-035 -> req1_ready at +1, req1_rvalid at +2 with req1_rdata=0xBEEF; req0_rdata unchanged.
REQ-037 Both ports hold valid loads continuously, FIXED_PRIO=0 -> grants alternate 01,10,01,10; each port one rvalid per 6 cycles.
REQ-038 Same stimulus, FIXED_PRIO=1 -> port 0 granted every transaction, port 1 never until req0_valid drops.
REQ-039 reset pulsed low during ACCESS of a store -> mem_write falls with reset, no ready pulse, state IDLE, memory word unchanged.
REQ-040 req1_valid raised in RESP of port 0 load -> not accepted until IDLE; granted next cycle, ready one cycle after that.
